bus_source_arbiter: RTL and testbench



---
 rtl/bus_source_arbiter_pkg.sv | 38 +++
 rtl/bus_source_arbiter_rr_picker.sv | 37 +++
 rtl/bus_source_arbiter.sv | 92 +++++++++
 tb/tb_bus_source_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the datapath bus arbiter: source indices, idle select
// code and arbiter state encoding.
package bus_source_arbiter_pkg;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  localparam logic [4:0] BUS_SEL_IDLE = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

endpackage

// File: rtl/bus_source_arbiter_rr_picker.sv
// Combinational rotating-priority picker: lowest set req index at or above ptr
// wins, otherwise the lowest set index overall (wrap-around).
module rr_picker #(
  parameter int N  = 24,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] winner
);

  logic          w_found_hi, w_found_lo;
  logic [PW-1:0] w_win_hi, w_win_lo;

  // Descending scan: the last hit written is the lowest matching index.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_found_lo = 1'b1;
        w_win_lo   = PW'(i);
        if (PW'(i) >= ptr) begin
          w_found_hi = 1'b1;
          w_win_hi   = PW'(i);
        end
      end
    end
  end

  assign found  = w_found_hi | w_found_lo;
  assign winner = w_found_hi ? w_win_hi : w_win_lo;

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the datapath bus with bounded tenure and a mandatory
// one-cycle turnaround between grants.
module bus_source_arbiter
  import bus_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = 24,
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [4:0]         bus_sel,
  output logic               bus_busy,
  output logic               hold_expired
);

  localparam int PW = $clog2(NUM_SRC);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

  state_e             r_state;
  logic [PW-1:0]      r_ptr, r_owner;
  logic [HW-1:0]      r_hold_cnt;
  logic [NUM_SRC-1:0] r_grant;
  logic [4:0]         r_bus_sel;
  logic               r_busy, r_hold_exp;

  logic               w_found, w_owner_req, w_hold_hit;
  logic [PW-1:0]      w_winner, w_next_ptr;

  rr_picker #(.N(NUM_SRC), .PW(PW)) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .found  (w_found),
    .winner (w_winner)
  );

  assign w_next_ptr  = (w_winner == PW'(NUM_SRC - 1)) ? '0 : w_winner + 1'b1;
  assign w_owner_req = req[r_owner];
  assign w_hold_hit  = (MAX_HOLD != 0) && (r_hold_cnt == HW'(MAX_HOLD));

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_hold_cnt <= '0;
      r_grant    <= '0;
      r_bus_sel  <= BUS_SEL_IDLE;
      r_busy     <= 1'b0;
      r_hold_exp <= 1'b0;
    end else begin
      r_hold_exp <= 1'b0;
      case (r_state)
        ST_GRANT: begin
          // A release wins over expiry, so hold_expired only fires while the owner still asks.
          if (!w_owner_req || w_hold_hit) begin
            r_state    <= ST_TURN;
            r_grant    <= '0;
            r_bus_sel  <= BUS_SEL_IDLE;
            r_busy     <= 1'b0;
            r_hold_exp <= w_owner_req;
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        default: begin
          if (w_found) begin
            r_state    <= ST_GRANT;
            r_owner    <= w_winner;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= HW'(1);
            r_grant    <= NUM_SRC'(1) << w_winner;
            r_bus_sel  <= 5'(w_winner) + 5'd1;
            r_busy     <= 1'b1;
          end else begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_bus_sel  <= BUS_SEL_IDLE;
            r_busy     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign bus_sel      = r_bus_sel;
  assign bus_busy     = r_busy;
  assign hold_expired = r_hold_exp;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Three arbiters (MAX_HOLD 8, 2, 0) checked every cycle against a tenure-level
// model, with directed scenarios followed by randomized request traffic.
module tb_bus_source_arbiter;
  import bus_source_arbiter_pkg::*;

  localparam int N = 24;

  logic              clock = 1'b0;
  logic              clear_n;
  logic [2:0][N-1:0] rq;
  logic [2:0][N-1:0] gr;
  logic [2:0][4:0]   bs;
  logic [2:0]        bb, he;

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  bus_source_arbiter #(.NUM_SRC(N), .MAX_HOLD(8)) u_dut0 (
    .clock(clock), .clear_n(clear_n), .req(rq[0]), .grant(gr[0]),
    .bus_sel(bs[0]), .bus_busy(bb[0]), .hold_expired(he[0]));
  bus_source_arbiter #(.NUM_SRC(N), .MAX_HOLD(2)) u_dut1 (
    .clock(clock), .clear_n(clear_n), .req(rq[1]), .grant(gr[1]),
    .bus_sel(bs[1]), .bus_busy(bb[1]), .hold_expired(he[1]));
  bus_source_arbiter #(.NUM_SRC(N), .MAX_HOLD(0)) u_dut2 (
    .clock(clock), .clear_n(clear_n), .req(rq[2]), .grant(gr[2]),
    .bus_sel(bs[2]), .bus_busy(bb[2]), .hold_expired(he[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a source owns the bus for a tenure; any owner-less cycle arbitrates.
  int mh      [3] = '{8, 2, 0};
  int m_ptr   [3];
  int m_owner [3];
  int m_held  [3];
  bit m_exp   [3];

  always @(posedge clock or negedge clear_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!clear_n) begin
        m_ptr[d] = 0; m_owner[d] = -1; m_held[d] = 0; m_exp[d] = 1'b0;
      end else begin
        m_exp[d] = 1'b0;
        if (m_owner[d] >= 0) begin
          if (!rq[d][m_owner[d]]) m_owner[d] = -1;
          else if (mh[d] != 0 && m_held[d] == mh[d]) begin
            m_owner[d] = -1; m_exp[d] = 1'b1;
          end else m_held[d]++;
        end else begin
          for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr[d] + k) % N;
            if (m_owner[d] < 0 && rq[d][idx]) begin
              m_owner[d] = idx; m_held[d] = 1; m_ptr[d] = (idx + 1) % N;
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      logic [N-1:0] eg;
      eg = (m_owner[d] >= 0) ? (N'(1) << m_owner[d]) : '0;
      chk($sformatf("d%0d grant", d), 32'(gr[d]), 32'(eg));
      chk($sformatf("d%0d bus_sel", d), 32'(bs[d]), 32'(m_owner[d] + 1));
      chk($sformatf("d%0d bus_busy", d), 32'(bb[d]), 32'(m_owner[d] >= 0));
      chk($sformatf("d%0d hold_expired", d), 32'(he[d]), 32'(m_exp[d]));
    end
  end

  int rr_sel [19] = '{3,3,0,8,8,0,24,24,0,3,3,0,8,8,0,24,24,0,1};
  int rr_he  [19] = '{0,0,1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,0,0};
  int pc_sel [6]  = '{21,21,21,0,0,0};

  initial begin
    clear_n = 1'b0;
    rq = '0;
    repeat (3) @(negedge clock);
    chk("reset grant", 32'(gr[0]), 0);
    chk("reset bus_sel", 32'(bs[0]), 0);
    chk("reset bus_busy", 32'(bb[0]), 0);
    chk("reset hold_expired", 32'(he[0]), 0);
    clear_n = 1'b1;

    // Single requester: PC for three cycles.
    @(negedge clock);
    rq[0] = N'(1) << SRC_PC;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      chk($sformatf("pc bus_sel[%0d]", j), 32'(bs[0]), 32'(pc_sel[j]));
      if (j == 2) rq[0] = '0;
    end
    chk("pc release hold_expired", 32'(he[0]), 0);

    // Round-robin with MAX_HOLD=2, then owner drops on its last cycle.
    @(negedge clock);
    rq[1] = (N'(1) << 2) | (N'(1) << 7) | (N'(1) << 23);
    for (int j = 0; j < 19; j++) begin
      @(negedge clock);
      chk($sformatf("rr bus_sel[%0d]", j), 32'(bs[1]), 32'(rr_sel[j]));
      chk($sformatf("rr hold_expired[%0d]", j), 32'(he[1]), 32'(rr_he[j]));
      if (j == 16) rq[1] = (N'(1) << 0) | (N'(1) << 22);
    end
    rq[1] = '0;

    // Unlimited hold: MDR keeps the bus while others wait.
    @(negedge clock);
    rq[2] = N'(1) << SRC_MDR;
    for (int j = 0; j < 40; j++) begin
      @(negedge clock);
      chk($sformatf("mdr bus_sel[%0d]", j), 32'(bs[2]), 22);
      chk($sformatf("mdr hold_expired[%0d]", j), 32'(he[2]), 0);
      if (j == 0) rq[2] = rq[2] | (N'(1) << 1) | (N'(1) << 5) | (N'(1) << SRC_C);
    end
    rq[2] = '0;

    // Reset in the middle of a tenure.
    @(negedge clock);
    rq[0] = '1;
    repeat (3) @(negedge clock);
    chk("pre-reset bus_busy", 32'(bb[0]), 1);
    #2 clear_n = 1'b0;
    #1;
    chk("async grant", 32'(gr[0]), 0);
    chk("async bus_sel", 32'(bs[0]), 0);
    chk("async bus_busy", 32'(bb[0]), 0);
    @(negedge clock);
    rq[0] = N'(1) << 5;
    clear_n = 1'b1;
    @(negedge clock);
    chk("post-reset bus_sel", 32'(bs[0]), 6);
    rq[0] = '0;

    // Randomized traffic on all three arbiters.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clock);
      #1;
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(3) == 0) begin
          case ($urandom_range(3))
            0: rq[d] = '0;
            1: rq[d] = N'(1) << $urandom_range(N - 1);
            2: rq[d] = N'($urandom & $urandom);
            default: rq[d] = N'($urandom);
          endcase
        end
      end
      clear_n = ($urandom_range(499) != 0);
    end
    clear_n = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
